// File: rtl/mtr_drv_n_if.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_n_if
// Brief    : Request/gate bundle between the balance controller and the
//            N-channel H-bridge PWM driver.
// Revision : 1.0 - initial release
// ============================================================================
interface mtr_drv_n_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 11
);
    logic [CHANNELS*WIDTH-1:0] spd;
    logic [CHANNELS-1:0]       rev;
    logic [CHANNELS-1:0]       PWM_frwrd;
    logic [CHANNELS-1:0]       PWM_rev;
    logic [CHANNELS-1:0]       in_dead;

    modport master (
        output spd,
        output rev,
        input  PWM_frwrd,
        input  PWM_rev,
        input  in_dead
    );

    modport slave (
        input  spd,
        input  rev,
        output PWM_frwrd,
        output PWM_rev,
        output in_dead
    );
endinterface
`default_nettype wire

// File: rtl/mtr_drv_n.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_n
// Brief    : N-channel H-bridge PWM driver with a shared period counter,
//            boundary-only duty updates and reversal dead time.
//            Define MTR_DRV_SLEW_EN to slew-limit duty changes by SLEW_STEP.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_drv_n #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 11,
    parameter int DEAD_CYCLES = 64,
    parameter int SLEW_STEP   = 16
) (
    input  wire         clk,
    input  wire         rst,
    mtr_drv_n_if.slave  bus
);

    localparam int                c_DW        = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [c_DW-1:0]   c_DEAD_LOAD = c_DW'(DEAD_CYCLES);
    localparam logic [WIDTH-1:0]  c_CNT_MAX   = {WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_DRIVE = 1'b0,
        ST_DEAD  = 1'b1
    } state_t;

    logic [WIDTH-1:0]    r_cnt;
    logic                w_boundary;
    logic [CHANNELS-1:0] w_frwrd;
    logic [CHANNELS-1:0] w_rev;
    logic [CHANNELS-1:0] w_dead;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign w_boundary    = (r_cnt == c_CNT_MAX);
    assign bus.PWM_frwrd = w_frwrd;
    assign bus.PWM_rev   = w_rev;
    assign bus.in_dead   = w_dead;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
        logic [WIDTH-1:0] w_req;
        logic             w_rev_req;
        logic [WIDTH-1:0] w_next_duty;
        logic             w_pwm;

        state_t           r_state;
        logic [WIDTH-1:0] r_duty;
        logic             r_dir;
        logic [c_DW-1:0]  r_dead_cnt;
        logic             r_frwrd;
        logic             r_rev;
        logic             r_in_dead;

        assign w_req     = bus.spd[gi*WIDTH +: WIDTH];
        assign w_rev_req = bus.rev[gi];

`ifdef MTR_DRV_SLEW_EN
        // Step is clamped to full scale so it can never wrap the duty register.
        localparam int               c_STEP_SAT = (SLEW_STEP > (1 << WIDTH) - 1) ? (1 << WIDTH) - 1 : SLEW_STEP;
        localparam logic [WIDTH:0]   c_STEP     = (WIDTH+1)'(c_STEP_SAT);

        logic [WIDTH:0] w_up_gap;
        logic [WIDTH:0] w_dn_gap;

        always_comb begin
            w_up_gap    = {1'b0, w_req} - {1'b0, r_duty};
            w_dn_gap    = {1'b0, r_duty} - {1'b0, w_req};
            w_next_duty = w_req;
            if (w_req > r_duty) begin
                if (w_up_gap > c_STEP) begin
                    w_next_duty = r_duty + c_STEP[WIDTH-1:0];
                end
            end else if (w_dn_gap > c_STEP) begin
                w_next_duty = r_duty - c_STEP[WIDTH-1:0];
            end
        end
`else
        assign w_next_duty = w_req;
`endif

        assign w_pwm = (r_cnt < r_duty) && (r_state == ST_DRIVE);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= ST_DRIVE;
                r_duty     <= '0;
                r_dir      <= 1'b0;
                r_dead_cnt <= '0;
                r_frwrd    <= 1'b0;
                r_rev      <= 1'b0;
                r_in_dead  <= 1'b0;
            end else begin
                r_frwrd <= w_pwm & ~r_dir;
                r_rev   <= w_pwm & r_dir;
                case (r_state)
                    ST_DRIVE: begin
                        if (w_boundary) begin
                            if ((w_rev_req == r_dir) || (DEAD_CYCLES == 0)) begin
                                r_dir  <= w_rev_req;
                                r_duty <= w_next_duty;
                            end else begin
                                r_state    <= ST_DEAD;
                                r_in_dead  <= 1'b1;
                                r_duty     <= '0;
                                r_dead_cnt <= c_DEAD_LOAD;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (r_dead_cnt != '0) begin
                            r_dead_cnt <= r_dead_cnt - c_DW'(1);
                        end
                        // Exit needs the counter already at zero; direction is resampled here.
                        if (w_boundary && (r_dead_cnt == '0)) begin
                            r_state   <= ST_DRIVE;
                            r_in_dead <= 1'b0;
                            r_dir     <= w_rev_req;
                            r_duty    <= w_next_duty;
                        end
                    end
                    default: begin
                        r_state <= ST_DRIVE;
                    end
                endcase
            end
        end

        assign w_frwrd[gi] = r_frwrd;
        assign w_rev[gi]   = r_rev;
        assign w_dead[gi]  = r_in_dead;
    end

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_drv_n
// Brief    : Period-window scoreboard bench for mtr_drv_n (dead-time instance
//            plus a zero-dead-time instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtr_drv_n;

    localparam int CH   = 2;
    localparam int W    = 4;
    localparam int DEAD = 5;
    localparam int STEP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    mtr_drv_n_if #(.CHANNELS(CH), .WIDTH(W)) ifa ();
    mtr_drv_n_if #(.CHANNELS(CH), .WIDTH(W)) ifb ();

    mtr_drv_n #(.CHANNELS(CH), .WIDTH(W), .DEAD_CYCLES(DEAD), .SLEW_STEP(STEP)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mtr_drv_n #(.CHANNELS(CH), .WIDTH(W), .DEAD_CYCLES(0), .SLEW_STEP(STEP)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    typedef struct {
        logic [15:0] f0, r0, f1, r1, d0, fb, rb;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_k  = -2;
    bit          sb_en   = 1'b1;
    logic [3:0]  s1_val  = 4'd5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] msk(input int n);
        logic [16:0] one;
        one = 17'd1;
        return 16'((one << n) - 17'd1);
    endfunction

    // Edge index since reset release: -1 means the last edge was a reset edge.
    initial forever begin
        @(posedge clk);
        if (rst) edge_k = -1;
        else if (edge_k >= -1) edge_k = edge_k + 1;
    end

    initial begin : mon
        logic [15:0] wf0, wr0, wf1, wr1, wfb, wrb, dacc, dwin;
        int          last_f[CH];
        int          last_r[CH];
        int          j;
        int          dj;
        exp_t        e;
        wf0 = '0; wr0 = '0; wf1 = '0; wr1 = '0; wfb = '0; wrb = '0; dacc = '0; dwin = '0;
        for (int i = 0; i < CH; i++) begin
            last_f[i] = -1000;
            last_r[i] = -1000;
        end
        forever begin
            @(negedge clk);
            if (edge_k >= -1) begin
                check("excl_a", 32'(ifa.PWM_frwrd & ifa.PWM_rev), 32'd0);
                check("excl_b", 32'(ifb.PWM_frwrd & ifb.PWM_rev), 32'd0);
            end
            if (edge_k == -1) begin
                check("rst_out", 32'({ifa.PWM_frwrd, ifa.PWM_rev, ifa.in_dead,
                                      ifb.PWM_frwrd, ifb.PWM_rev, ifb.in_dead}), 32'd0);
                wf0 = '0; wr0 = '0; wf1 = '0; wr1 = '0; wfb = '0; wrb = '0; dacc = '0; dwin = '0;
                for (int i = 0; i < CH; i++) begin
                    last_f[i] = -1000;
                    last_r[i] = -1000;
                end
            end else if (edge_k >= 0) begin
                j  = edge_k % 16;
                dj = (edge_k + 1) % 16;
                wf0[j] = ifa.PWM_frwrd[0];
                wr0[j] = ifa.PWM_rev[0];
                wf1[j] = ifa.PWM_frwrd[1];
                wr1[j] = ifa.PWM_rev[1];
                wfb[j] = ifb.PWM_frwrd[0];
                wrb[j] = ifb.PWM_rev[0];
                dacc[dj] = ifa.in_dead[0];
                if (dj == 15) begin
                    dwin = dacc;
                    dacc = '0;
                end
                for (int i = 0; i < CH; i++) begin
                    if (ifa.PWM_rev[i]) begin
                        if (last_f[i] > last_r[i]) check("gap_rev", 32'((edge_k - last_f[i]) > DEAD), 32'd1);
                        last_r[i] = edge_k;
                    end
                    if (ifa.PWM_frwrd[i]) begin
                        if (last_r[i] > last_f[i]) check("gap_fwd", 32'((edge_k - last_r[i]) > DEAD), 32'd1);
                        last_f[i] = edge_k;
                    end
                end
                if (j == 15) begin
                    if (sb_en) begin
                        check("sb_avail", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            check("win_f0",   32'(wf0),  32'(e.f0));
                            check("win_r0",   32'(wr0),  32'(e.r0));
                            check("win_f1",   32'(wf1),  32'(e.f1));
                            check("win_r1",   32'(wr1),  32'(e.r1));
                            check("win_dead", 32'(dwin), 32'(e.d0));
                            check("win_fb0",  32'(wfb),  32'(e.fb));
                            check("win_rb0",  32'(wrb),  32'(e.rb));
                        end
                    end
                    wf0 = '0; wr0 = '0; wf1 = '0; wr1 = '0; wfb = '0; wrb = '0;
                end
            end
        end
    end

    task automatic set_req(input logic [3:0] s0, input logic r0);
        ifa.spd = {s1_val, s0};
        ifa.rev = {1'b0, r0};
        ifb.spd = {s1_val, s0};
        ifb.rev = {1'b0, r0};
    endtask

    task automatic push_exp(input int nf0, input int nr0, input int nf1, input bit dead,
                            input int nfb, input int nrb);
        exp_t e;
        e.f0 = msk(nf0);
        e.r0 = msk(nr0);
        e.f1 = msk(nf1);
        e.r1 = '0;
        e.d0 = dead ? 16'hFFFF : 16'h0000;
        e.fb = msk(nfb);
        e.rb = msk(nrb);
        sb_q.push_back(e);
    endtask

    // One PWM period of stimulus; the expectation is for the following output window.
    task automatic drive_period(input int mid, input logic [3:0] s0a, input logic [3:0] s0b,
                                input logic r0a, input logic r0b,
                                input int nf0, input int nr0, input int nf1, input bit dead,
                                input int nfb, input int nrb);
        set_req(s0a, r0a);
        push_exp(nf0, nr0, nf1, dead, nfb, nrb);
        repeat (mid) @(posedge clk);
        #1;
        set_req(s0b, r0b);
        repeat (16 - mid) @(posedge clk);
        #1;
    endtask

    initial begin
        set_req(4'd8, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 0, 0, 1'b0, 0, 0);
`ifdef MTR_DRV_SLEW_EN
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 2, 0, 2, 1'b0, 2, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 4, 0, 4, 1'b0, 4, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 6, 0, 5, 1'b0, 6, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 7, 0, 5, 1'b0, 7, 0);
        drive_period(5, 4'd1, 4'd1, 1'b0, 1'b0, 5, 0, 5, 1'b0, 5, 0);
        drive_period(5, 4'd1, 4'd1, 1'b0, 1'b0, 3, 0, 5, 1'b0, 3, 0);
        drive_period(5, 4'd1, 4'd1, 1'b0, 1'b0, 1, 0, 5, 1'b0, 1, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 3, 0, 5, 1'b0, 3, 0);
        // Reset in the middle of the 3-high window while ramping toward 7.
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 0, 0, 1'b0, 0, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 2, 0, 2, 1'b0, 2, 0);
        drive_period(5, 4'd7, 4'd7, 1'b0, 1'b0, 4, 0, 4, 1'b0, 4, 0);
        drive_period(3, 4'd7, 4'd7, 1'b0, 1'b1, 0, 0, 5, 1'b1, 0, 6);
        drive_period(3, 4'd7, 4'd7, 1'b1, 1'b1, 0, 2, 5, 1'b0, 0, 7);
        drive_period(3, 4'd7, 4'd7, 1'b1, 1'b1, 0, 4, 5, 1'b0, 0, 7);
`else
        drive_period(5, 4'd8,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(5, 4'd8,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(5, 4'd8,  4'd3,  1'b0, 1'b0, 3,  0, 5, 1'b0, 3,  0);
        drive_period(5, 4'd3,  4'd3,  1'b0, 1'b0, 3,  0, 5, 1'b0, 3,  0);
        drive_period(5, 4'd3,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(3, 4'd8,  4'd8,  1'b0, 1'b1, 0,  0, 5, 1'b1, 0,  8);
        drive_period(3, 4'd8,  4'd8,  1'b1, 1'b1, 0,  8, 5, 1'b0, 0,  8);
        drive_period(3, 4'd8,  4'd8,  1'b1, 1'b1, 0,  8, 5, 1'b0, 0,  8);
        drive_period(3, 4'd8,  4'd8,  1'b1, 1'b0, 0,  0, 5, 1'b1, 8,  0);
        drive_period(3, 4'd8,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(3, 4'd8,  4'd8,  1'b0, 1'b1, 0,  0, 5, 1'b1, 0,  8);
        drive_period(3, 4'd8,  4'd8,  1'b1, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(3, 4'd8,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
        drive_period(5, 4'd15, 4'd15, 1'b0, 1'b0, 15, 0, 5, 1'b0, 15, 0);
        drive_period(5, 4'd0,  4'd0,  1'b0, 1'b0, 0,  0, 5, 1'b0, 0,  0);
        drive_period(5, 4'd0,  4'd8,  1'b0, 1'b0, 8,  0, 5, 1'b0, 8,  0);
`endif
        repeat (16) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            ifa.spd = 8'($urandom_range(255));
            ifa.rev = 2'($urandom_range(3));
            ifb.spd = 8'($urandom_range(255));
            ifb.rev = 2'($urandom_range(3));
        end
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
